fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage against a variable-latency instruction memory using a req/ready request and an rvalid response.
- Drives the PC stall (i_con_ifstall of fetch) and the instruction word latched into the IF/ID register.
- Arbitrates branch/jump redirects and squashes any in-flight fetch that a redirect makes stale.
- At most one memory request outstanding.

Parameters:
- NOP_INSTR, 32'h0000_0013: bubble word driven on squash/idle cycles.
- CNT_W, 32: width of stall counter (optional feature only).

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous active-low reset
- i_con_b  in  1  branch taken (EX)
- i_con_j  in  2  jump request: 00 none, 01 j, 10 jr, 11 reserved (treated as none)
- i_con_dstall  in  1  decode/hazard stall request
- i_con_imem_ready  in  1  imem accepts request this cycle
- i_con_imem_rvalid  in  1  imem response valid
- i_data_imem_rdata  in  32  imem response data
- o_con_imem_req  out  1  request to imem (address = current PC, supplied elsewhere)
- o_con_ifstall  out  1  1 = PC holds; 0 = PC loads next-pc-mux output
- o_con_b  out  1  arbitrated branch select to next-pc mux
- o_con_j  out  2  arbitrated jump select to next-pc mux
- o_data_instr  out  32  instruction word to IF/ID register
- o_data_stallcnt  out  CNT_W  stall-cycle count

Behaviour:
- Reset (async, i_nrst=0): state IDLE; o_con_imem_req=0, o_con_ifstall=1, o_con_b=0, o_con_j=00, o_data_instr=NOP_INSTR, o_data_stallcnt=0.
- States: IDLE, REQ, WAIT, HOLD, KILL.
- IDLE: stall=1; go to REQ one cycle after reset release. Redirects are ignored in IDLE.
- Redirect = i_con_b | (i_con_j==01) | (i_con_j==10). Arbitration when both are set: branch wins, so o_con_b=1 and o_con_j=00; otherwise o_con_j=i_con_j. Outside IDLE, o_con_b=o_con_j=0 whenever no redirect is in effect.
- Redirect has the highest priority in REQ/WAIT/HOLD/KILL. In that same cycle: stall=0 (PC loads target), o_data_instr=NOP_INSTR, o_con_imem_req=0; dstall is ignored.
  - Next state is KILL if a request is outstanding (WAIT, KILL, or REQ accepted this cycle); otherwise REQ.
  - A redirect coinciding with rvalid discards that response and goes to REQ.
- REQ: req=1, stall=1, instr=NOP.
  - ready & rvalid in the same cycle (zero-wait memory) is a deliver event; state stays REQ.
  - ready only: go to WAIT.
- WAIT: req=0, stall=1, instr=NOP until rvalid. rvalid triggers a deliver event, then go to REQ.
- Deliver event:
  - dstall=0: instr=rdata and stall=0 for exactly that cycle, so PC advances and IF/ID captures rdata.
  - dstall=1: rdata is latched into the hold register; go to HOLD.
- HOLD: req=0, instr=NOP, stall=1 while dstall=1. When dstall falls: instr=held word, stall=0 for one cycle, then go to REQ.
- KILL: req=0, stall=1, instr=NOP. When rvalid arrives, discard rdata and go to REQ.
- Throughput: 1 instr/cycle with a zero-wait memory; 1 per (latency+1) cycles otherwise.
- All control outputs are combinational from state and inputs. State and hold register are registered.
- Invariant: rvalid never arrives with no request outstanding. The bench checks this; RTL behaviour in that case is don't-care.

Optional Feature:
- Macro FETCH_CTRL_PERF_EN.
- Defined: o_data_stallcnt increments every cycle with o_con_ifstall=1 outside IDLE, saturates at all-ones, and is cleared only by reset.
- Undefined: o_data_stallcnt is tied to 0 and no counter flops are synthesised.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - state enum (IDLE, REQ, WAIT, HOLD, KILL)
  - jump encodings J_NONE=00, J_J=01, J_JR=10
  - default NOP constant
- Sub-module F_redirect_arb: purely combinational branch/jump priority, producing o_con_b, o_con_j and the redirect flag.

Test Plan:
- Reset release, memory ready=1 with rvalid same cycle, rdata 0x00A00093 then 0x00100113 -> IDLE 1 cycle, then stall=0 every cycle and o_data_instr follows rdata back-to-back.
- 3-cycle latency memory (ready at request, rvalid 3 cycles later, rdata 0x12345678) -> req high 1 cycle, stall=1 for 3 cycles, then stall=0 and o_data_instr=0x12345678 for 1 cycle.
- Deliver with dstall=1 held 2 cycles, rdata 0xDEADBEEF -> HOLD: NOP with stall=1 for 2 cycles, then 0xDEADBEEF with stall=0 one cycle, then REQ.
- i_con_b=1 in WAIT, response 0xBAD00000 arrives 2 cycles later -> stall=0 and NOP in the redirect cycle; KILL; 0xBAD00000 never appears on o_data_instr; REQ follows.
- i_con_b=1 and i_con_j=10 same cycle -> o_con_b=1, o_con_j=00. i_con_j=11 alone -> no redirect.
- Reset asserted mid-WAIT -> all outputs return to reset values immediately. With FETCH_CTRL_PERF_EN, the counter equals the number of stall cycles (e.g. 3 after the latency-3 scenario) and is cleared by reset.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    KILL
  } state_t;

  localparam logic [1:0]  J_NONE      = 2'b00;
  localparam logic [1:0]  J_J         = 2'b01;
  localparam logic [1:0]  J_JR        = 2'b10;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake/bus bundle between the fetch controller and its surroundings.
// master = fetch controller side, slave = pipeline/memory side.
interface fetch_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             i_con_b;
  logic [1:0]       i_con_j;
  logic             i_con_dstall;
  logic             i_con_imem_ready;
  logic             i_con_imem_rvalid;
  logic [31:0]      i_data_imem_rdata;
  logic             o_con_imem_req;
  logic             o_con_ifstall;
  logic             o_con_b;
  logic [1:0]       o_con_j;
  logic [31:0]      o_data_instr;
  logic [CNT_W-1:0] o_data_stallcnt;

  modport master (
    input  i_con_b, i_con_j, i_con_dstall,
    input  i_con_imem_ready, i_con_imem_rvalid, i_data_imem_rdata,
    output o_con_imem_req, o_con_ifstall, o_con_b, o_con_j,
    output o_data_instr, o_data_stallcnt
  );

  modport slave (
    output i_con_b, i_con_j, i_con_dstall,
    output i_con_imem_ready, i_con_imem_rvalid, i_data_imem_rdata,
    input  o_con_imem_req, o_con_ifstall, o_con_b, o_con_j,
    input  o_data_instr, o_data_stallcnt
  );
endinterface

// File: rtl/F_redirect_arb.sv
// Branch/jump redirect arbitration: branch beats jump, the reserved jump
// code 11 is treated as no jump. Purely combinational.
module F_redirect_arb
  import fetch_ctrl_pkg::*;
(
  input  logic       b_in,
  input  logic [1:0] j_in,
  output logic       b_out,
  output logic [1:0] j_out,
  output logic       redirect
);

  logic j_valid;

  assign j_valid  = (j_in == J_J) || (j_in == J_JR);
  assign b_out    = b_in;
  assign j_out    = (!b_in && j_valid) ? j_in : J_NONE;
  assign redirect = b_in | j_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a variable-latency instruction memory.
// Keeps at most one request outstanding, squashes stale responses after a
// redirect and parks a delivered word while decode is stalled.
// Optional stall-cycle counter enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
  parameter int          CNT_W     = 32
) (
  input logic          i_clk,
  input logic          i_nrst,
  fetch_ctrl_if.master bus
);

  state_t      state;
  state_t      state_next;
  logic [31:0] hold_word;
  logic        hold_load;
  logic        deliver;
  logic        arb_b;
  logic [1:0]  arb_j;
  logic        redirect;

  F_redirect_arb u_arb (
    .b_in     (bus.i_con_b),
    .j_in     (bus.i_con_j),
    .b_out    (arb_b),
    .j_out    (arb_j),
    .redirect (redirect)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_next;
  end

  // Hold register: parks a delivered word while decode is stalled.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)        hold_word <= NOP_INSTR;
    else if (hold_load) hold_word <= bus.i_data_imem_rdata;
  end

  // Next-state and control outputs; a redirect overrides everything outside IDLE.
  always_comb begin
    state_next         = state;
    hold_load          = 1'b0;
    deliver            = 1'b0;
    bus.o_con_imem_req = 1'b0;
    bus.o_con_ifstall  = 1'b1;
    bus.o_data_instr   = NOP_INSTR;
    bus.o_con_b        = 1'b0;
    bus.o_con_j        = J_NONE;

    if (state != IDLE) begin
      bus.o_con_b = arb_b;
      bus.o_con_j = arb_j;
    end

    case (state)
      IDLE: state_next = REQ;

      REQ: begin
        if (redirect) begin
          bus.o_con_ifstall = 1'b0;
          // A same-cycle response means nothing is left in flight.
          state_next = (bus.i_con_imem_ready && !bus.i_con_imem_rvalid) ? KILL : REQ;
        end else begin
          bus.o_con_imem_req = 1'b1;
          if (bus.i_con_imem_ready && bus.i_con_imem_rvalid) deliver = 1'b1;
          else if (bus.i_con_imem_ready)                     state_next = WAIT;
        end
      end

      WAIT: begin
        if (redirect) begin
          bus.o_con_ifstall = 1'b0;
          state_next = bus.i_con_imem_rvalid ? REQ : KILL;
        end else if (bus.i_con_imem_rvalid) begin
          deliver = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          bus.o_con_ifstall = 1'b0;
          state_next = REQ;
        end else if (!bus.i_con_dstall) begin
          bus.o_con_ifstall = 1'b0;
          bus.o_data_instr  = hold_word;
          state_next        = REQ;
        end
      end

      KILL: begin
        if (redirect) begin
          bus.o_con_ifstall = 1'b0;
          state_next = bus.i_con_imem_rvalid ? REQ : KILL;
        end else if (bus.i_con_imem_rvalid) begin
          state_next = REQ;
        end
      end

      default: state_next = IDLE;
    endcase

    // Response hand-off: straight to IF/ID, or parked if decode is stalled.
    if (deliver) begin
      if (bus.i_con_dstall) begin
        hold_load  = 1'b1;
        state_next = HOLD;
      end else begin
        bus.o_con_ifstall = 1'b0;
        bus.o_data_instr  = bus.i_data_imem_rdata;
        state_next        = REQ;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of stalled cycles outside IDLE; only reset clears it.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)
      stall_cnt <= '0;
    else if ((state != IDLE) && bus.o_con_ifstall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.o_data_stallcnt = stall_cnt;
`else
  assign bus.o_data_stallcnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl with a flag-based reference model and a
// behavioural variable-latency instruction memory.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic nrst;

  fetch_ctrl_if #(.CNT_W(32)) bus ();

  fetch_ctrl #(.NOP_INSTR(NOP), .CNT_W(32)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model state (fetch-level facts, not controller states).
  bit          started;
  bit          outstanding;
  bit          stale;
  bit          holding;
  logic [31:0] held;
  int          exp_cnt;

  // Memory model state and stimulus knobs.
  bit          mem_busy;
  int          mem_cnt;
  int          ready_pct, lat_min, lat_max, redir_pct, dstall_pct;
  logic [31:0] word_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_word();
    if (word_q.size() > 0) return word_q.pop_front();
    return $urandom;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_req"},   32'(bus.o_con_imem_req), 32'd0);
    chk_eq({tag, "_stall"}, 32'(bus.o_con_ifstall),  32'd1);
    chk_eq({tag, "_b"},     32'(bus.o_con_b),        32'd0);
    chk_eq({tag, "_j"},     32'(bus.o_con_j),        32'd0);
    chk_eq({tag, "_instr"}, bus.o_data_instr,        NOP);
    chk_eq({tag, "_cnt"},   bus.o_data_stallcnt,     32'd0);
  endtask

  task automatic model_reset();
    started = 0; outstanding = 0; stale = 0; holding = 0; held = NOP;
    exp_cnt = 0; mem_busy = 0; mem_cnt = 0;
  endtask

  task automatic idle_inputs();
    bus.i_con_b = 1'b0; bus.i_con_j = 2'b00; bus.i_con_dstall = 1'b0;
    bus.i_con_imem_ready = 1'b0; bus.i_con_imem_rvalid = 1'b0;
    bus.i_data_imem_rdata = 32'h0;
  endtask

  // One cycle: drive inputs, let outputs settle, compare with model, advance model.
  task automatic eval();
    logic        b, dst, rdy, rv, redir, exp_req, exp_stall, exp_b, deliver;
    logic [1:0]  j, exp_j;
    logic [31:0] rdata, exp_instr;
    int          lat;

    if ($urandom_range(99) < redir_pct) begin
      b = 1'($urandom_range(1));
      j = 2'($urandom_range(3));
      if (!b && !(j == 2'b01 || j == 2'b10)) b = 1'b1;
    end else begin
      b = 1'b0;
      j = ($urandom_range(7) == 0) ? 2'b11 : 2'b00;
    end
    dst   = ($urandom_range(99) < dstall_pct);
    redir = b || (j == 2'b01) || (j == 2'b10);
    exp_req = started && !redir && !outstanding && !holding;

    rdy = 1'b0; rv = 1'b0; rdata = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1; rdata = next_word(); mem_busy = 0;
      end
    end else if (exp_req && ($urandom_range(99) < ready_pct)) begin
      rdy = 1'b1;
      lat = $urandom_range(lat_max, lat_min);
      if (lat == 0) begin
        rv = 1'b1; rdata = next_word();
      end else begin
        mem_busy = 1; mem_cnt = lat;
      end
    end

    bus.i_con_b = b; bus.i_con_j = j; bus.i_con_dstall = dst;
    bus.i_con_imem_ready = rdy; bus.i_con_imem_rvalid = rv;
    bus.i_data_imem_rdata = rdata;
    #1;

    exp_stall = 1'b1; exp_instr = NOP; exp_b = 1'b0; exp_j = 2'b00; deliver = 1'b0;
    if (!started) begin
      started = 1;
    end else begin
      exp_b = b;
      exp_j = (b || !redir) ? 2'b00 : j;
      if (redir) begin
        exp_stall = 1'b0;
        if (rv) outstanding = 0;
        stale   = outstanding;
        holding = 0;
      end else if (holding) begin
        if (!dst) begin
          exp_stall = 1'b0; exp_instr = held; holding = 0;
        end
      end else if (outstanding) begin
        if (rv) begin
          outstanding = 0;
          if (stale) stale = 0;
          else       deliver = 1'b1;
        end
      end else begin
        if (rdy && rv)  deliver = 1'b1;
        else if (rdy) begin
          outstanding = 1; stale = 0;
        end
      end
      if (deliver) begin
        if (dst) begin
          holding = 1; held = rdata;
        end else begin
          exp_stall = 1'b0; exp_instr = rdata;
        end
      end
      if (exp_stall) exp_cnt++;
    end

    chk_eq("req",   32'(bus.o_con_imem_req), 32'(exp_req));
    chk_eq("stall", 32'(bus.o_con_ifstall),  32'(exp_stall));
    chk_eq("b",     32'(bus.o_con_b),        32'(exp_b));
    chk_eq("j",     32'(bus.o_con_j),        32'(exp_j));
    chk_eq("instr", bus.o_data_instr,        exp_instr);
`ifdef FETCH_CTRL_PERF_EN
    chk_eq("cnt",   bus.o_data_stallcnt,     32'(exp_cnt));
`else
    chk_eq("cnt",   bus.o_data_stallcnt,     32'd0);
`endif
    if (!exp_stall && !redir)
      $display("deliver instr=%h t=%0t", exp_instr, $time);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      eval();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    nrst = 1'b0;
    idle_inputs();
    model_reset();
    ready_pct = 100; lat_min = 0; lat_max = 0; redir_pct = 0; dstall_pct = 0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst0");

    // Zero-wait memory: one instruction per cycle after the IDLE cycle.
    word_q.push_back(32'h00A0_0093);
    word_q.push_back(32'h0010_0113);
    @(negedge clk);
    nrst = 1'b1;
    eval();
    run(6);

    // Latency-3 memory.
    lat_min = 3; lat_max = 3;
    word_q.push_back(32'h1234_5678);
    run(12);

    // Decode stalls against a latency-1 memory.
    lat_min = 1; lat_max = 1; dstall_pct = 60;
    word_q.push_back(32'hDEAD_BEEF);
    run(40);

    // Full random mix: redirects, stalls, variable latency, sparse ready.
    ready_pct = 70; lat_min = 0; lat_max = 3; redir_pct = 15; dstall_pct = 30;
    word_q.push_back(32'hBAD0_0000);
    run(2000);

    // Reset asserted while a response is pending.
    lat_min = 2; lat_max = 3; redir_pct = 0;
    for (int k = 0; k < 60 && !(outstanding && !stale); k++) begin
      @(negedge clk);
      eval();
    end
    chk_eq("reach_wait", 32'(outstanding && !stale), 32'd1);
    #2;
    nrst = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    nrst = 1'b1;
    eval();

    ready_pct = 80; lat_min = 0; lat_max = 3; redir_pct = 20; dstall_pct = 25;
    run(800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
